lcd_nibble_writer: RTL and testbench

- Responder end of the CPU→LCD byte handshake (`iData`/`iData_Ready` in, `oReadyForData` out).
- Drives the 4-bit HD44780-compatible character LCD on the board at 50 MHz:
  - runs the power-on initialisation sequence once after reset;
  - then accepts one byte at a time and serialises it as two enable-strobed nibbles with the required setup/hold/execution delays.
- The `LCD` instruction of the CPU presents a byte; `BNLCD` polls `oReadyForData`.

---
 rtl/lcd_nibble_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// 4-bit HD44780 LCD writer: power-on init, fixed configuration, then one byte per handshake,
// each byte sent as two enable-strobed nibbles (upper first).
module lcd_nibble_writer #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned INIT_WAIT0     = 205000,
  parameter int unsigned INIT_WAIT1     = 5000,
  parameter int unsigned EXEC_CYCLES    = 2000,
  parameter int unsigned CLEAR_CYCLES   = 82000,
  parameter int unsigned PULSE_CYCLES   = 12,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iIsCommand,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [3:0] {
    StPowerup, StInitNib, StInitPulse, StInitHold, StInitWait, StIdle,
    StHiSetup, StHiPulse, StHiHold, StGap, StLoSetup, StLoPulse, StLoHold, StPostWait
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;    // init nibble index, or config byte index while cfg_q
  logic        cfg_q, cfg_d;
  logic [7:0]  byte_q, byte_d;
  logic        cmd_q, cmd_d;
  logic        e_q, e_d, rs_q, rs_d, ready_q, ready_d;
  logic [3:0]  data_q, data_d;
  logic        accept;
  logic        long_wait;

  // Counter holds N-1 on state entry; the state ends when it reaches 0.
  function automatic logic [19:0] load(input int unsigned n);
    return 20'(n - 1);
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [19:0] init_wait(input logic [1:0] i);
    case (i)
      2'd0:    return load(INIT_WAIT0);
      2'd1:    return load(INIT_WAIT1);
      default: return load(EXEC_CYCLES);
    endcase
  endfunction

  assign long_wait = cmd_q && (byte_q == 8'h01 || byte_q == 8'h02);
  // A byte is taken only once the ready flag is visible to the CPU.
  assign accept    = (state_q == StIdle) && ready_q && iData_Ready;

  // Next-state, counter and byte latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 20'd1;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    byte_d  = byte_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      StPowerup: if (cnt_q == '0) begin
        state_d = StInitNib;
        idx_d   = 2'd0;
        cnt_d   = load(SETUP_CYCLES);
      end
      StInitNib: if (cnt_q == '0) begin
        state_d = StInitPulse;
        cnt_d   = load(PULSE_CYCLES);
      end
      StInitPulse: if (cnt_q == '0) begin
        state_d = StInitHold;
        cnt_d   = load(1);
      end
      StInitHold: if (cnt_q == '0) begin
        state_d = StInitWait;
        cnt_d   = init_wait(idx_q);
      end
      StInitWait: if (cnt_q == '0) begin
        if (idx_q == 2'd3) begin
          cfg_d   = 1'b1;
          idx_d   = 2'd0;
          byte_d  = cfg_byte(2'd0);
          cmd_d   = 1'b1;
          state_d = StHiSetup;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StInitNib;
        end
        cnt_d = load(SETUP_CYCLES);
      end
      StIdle: begin
        cnt_d = cnt_q;
        if (accept) begin
          byte_d  = iData;
          cmd_d   = iIsCommand;
          state_d = StHiSetup;
          cnt_d   = load(SETUP_CYCLES);
        end
      end
      StHiSetup: if (cnt_q == '0) begin
        state_d = StHiPulse;
        cnt_d   = load(PULSE_CYCLES);
      end
      StHiPulse: if (cnt_q == '0) begin
        state_d = StHiHold;
        cnt_d   = load(1);
      end
      StHiHold: if (cnt_q == '0) begin
        state_d = StGap;
        cnt_d   = load(GAP_CYCLES);
      end
      StGap: if (cnt_q == '0) begin
        state_d = StLoSetup;
        cnt_d   = load(SETUP_CYCLES);
      end
      StLoSetup: if (cnt_q == '0) begin
        state_d = StLoPulse;
        cnt_d   = load(PULSE_CYCLES);
      end
      StLoPulse: if (cnt_q == '0) begin
        state_d = StLoHold;
        cnt_d   = load(1);
      end
      StLoHold: if (cnt_q == '0) begin
        state_d = StPostWait;
        cnt_d   = long_wait ? load(CLEAR_CYCLES) : load(EXEC_CYCLES);
      end
      StPostWait: if (cnt_q == '0) begin
        if (cfg_q && idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          byte_d  = cfg_byte(idx_q + 2'd1);
          cmd_d   = 1'b1;
          state_d = StHiSetup;
          cnt_d   = load(SETUP_CYCLES);
        end else begin
          cfg_d   = 1'b0;
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StPowerup;
        cnt_d   = load(POWERUP_CYCLES);
      end
    endcase
  end

  // Output next values decoded from the next state so every pin is a flop.
  always_comb begin
    e_d     = state_d inside {StInitPulse, StHiPulse, StLoPulse};
    ready_d = (state_q == StIdle) && !accept;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_d)
      StInitNib, StInitPulse, StInitHold: begin
        rs_d   = 1'b0;
        data_d = (idx_d == 2'd3) ? 4'h2 : 4'h3;
      end
      StHiSetup, StHiPulse, StHiHold: begin
        rs_d   = ~cmd_d;
        data_d = byte_d[7:4];
      end
      StLoSetup, StLoPulse, StLoHold: begin
        rs_d   = ~cmd_d;
        data_d = byte_d[3:0];
      end
      default: ;
    endcase
  end

  // State and output registers; reset re-enters POWERUP with its delay preloaded.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StPowerup;
      cnt_q   <= load(POWERUP_CYCLES);
      idx_q   <= 2'd0;
      cfg_q   <= 1'b0;
      byte_q  <= 8'h00;
      cmd_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 4'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      byte_q  <= byte_d;
      cmd_q   <= cmd_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign oReadyForData           = ready_q;
  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = data_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Scoreboard bench for lcd_nibble_writer: stimulus queues expected nibbles, a negedge monitor
// checks every enable strobe against them.
module tb_lcd_nibble_writer;
  localparam int unsigned PowerUp = 20, W0 = 10, W1 = 6, Exec = 4, Clear = 8;
  localparam int unsigned Pulse = 3, Setup = 2, Gap = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       is_cmd = 1'b0, dr = 1'b0;
  logic       ready, e, rs, rw, sf;
  logic [3:0] data;

  lcd_nibble_writer #(
    .POWERUP_CYCLES(PowerUp), .INIT_WAIT0(W0), .INIT_WAIT1(W1), .EXEC_CYCLES(Exec),
    .CLEAR_CYCLES(Clear), .PULSE_CYCLES(Pulse), .SETUP_CYCLES(Setup), .GAP_CYCLES(Gap)
  ) dut (
    .Clock(clk), .Reset(rst_n), .iData(din), .iIsCommand(is_cmd), .iData_Ready(dr),
    .oReadyForData(ready), .oLCD_Enabled(e), .oLCD_RegisterSelect(rs),
    .oLCD_ReadWrite(rw), .oLCD_StrataFlashControl(sf), .oLCD_Data(data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [4:0] exp_q[$];   // {rs, nibble}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each byte is upper then lower nibble; RS is the inverse of the command flag.
  task automatic push_byte(input logic [7:0] b, input logic cmd);
    exp_q.push_back({~cmd, b[7:4]});
    exp_q.push_back({~cmd, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(8'h28, 1'b1);
    push_byte(8'h06, 1'b1);
    push_byte(8'h0C, 1'b1);
    push_byte(8'h01, 1'b1);
  endtask

  function automatic int occupancy(input logic [7:0] b, input logic cmd);
    int w;
    w = (cmd && (b == 8'h01 || b == 8'h02)) ? Clear : Exec;
    return 2 * (Setup + Pulse + 1) + Gap + w + 1;
  endfunction

  // Monitor: nibble content at E rise, setup stability, pulse width and hold value at E fall.
  logic       e_prev = 1'b0;
  int         width = 0;
  logic [4:0] cur, pulse_val, hist1 = '0, hist2 = '0, expn;
  always @(negedge clk) begin
    cur = {rs, data};
    if (!rst_n) begin
      e_prev = 1'b0;
      width  = 0;
    end else begin
      if (e && !e_prev) begin
        width     = 1;
        pulse_val = cur;
        chk("setup_stable", {22'd0, hist2, hist1}, {22'd0, cur, cur});
        chk("rw_sf", {30'd0, rw, sf}, 32'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_nibble: got %0h expected none", cur);
        end else begin
          expn = exp_q.pop_front();
          chk("nibble", {27'd0, cur}, {27'd0, expn});
        end
      end else if (e) begin
        width++;
        chk("pulse_stable", {27'd0, cur}, {27'd0, pulse_val});
      end else if (e_prev) begin
        chk("pulse_width", width, Pulse);
        chk("hold_value", {27'd0, cur}, {27'd0, pulse_val});
      end
      e_prev = e;
    end
    hist2 = hist1;
    hist1 = cur;
  end

  task automatic measure_low(output int n);
    bit done;
    n    = 0;
    done = 0;
    for (int g = 0; g < 5000 && !done; g++) begin
      @(negedge clk);
      if (ready) done = 1;
      else n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 5000 cycles");
    end
  endtask

  // Issue one byte; optional strobe of 0x42 or a reset at a given low-ready cycle count.
  task automatic send(input logic [7:0] b, input logic cmd, input int strobe_at,
                      input int abort_at);
    int  n;
    bit  done;
    din    = b;
    is_cmd = cmd;
    dr     = 1'b1;
    push_byte(b, cmd);
    n    = 0;
    done = 0;
    for (int g = 0; g < 5000 && !done; g++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        n++;
        dr = (n == strobe_at);
        if (dr) din = 8'h42;
        if (n == abort_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          chk("abort_e", {31'd0, e}, 32'd0);
          chk("abort_data", {28'd0, data}, 32'd0);
          return;
        end
      end
    end
    dr = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 5000 cycles");
    end else begin
      chk("occupancy", n, occupancy(b, cmd));
      chk("drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    int         n;
    logic [7:0] b;
    logic       c;
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {23'd0, ready, e, rs, rw, sf, data}, 32'h010);
    end
    push_init();
    rst_n = 1'b1;
    measure_low(n);
    chk("init_drained", exp_q.size(), 0);

    send(8'h41, 1'b0, 0, 0);
    send(8'h01, 1'b1, 0, 0);
    // Strobe 0x42 during the upper-nibble pulse; it must be dropped.
    send(8'h41, 1'b0, 4, 0);
    repeat (30) @(negedge clk);
    chk("busy_no_extra", exp_q.size(), 0);

    // Level-held strobe: accepted, released, accepted again one cycle after ready.
    din    = 8'h30;
    is_cmd = 1'b0;
    dr     = 1'b1;
    push_byte(8'h30, 1'b0);
    push_byte(8'h30, 1'b0);
    measure_low(n);
    chk("held_first", n, occupancy(8'h30, 1'b0));
    @(negedge clk);
    chk("held_reaccept", {31'd0, ready}, 32'd0);
    dr = 1'b0;
    measure_low(n);
    chk("held_second", n, occupancy(8'h30, 1'b0) - 1);
    chk("held_drained", exp_q.size(), 0);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(1, 2));
        c = 1'b1;
      end
      send(b, c, 0, 0);
    end

    // Reset during the lower-nibble pulse, then full re-initialisation.
    send(8'h41, 1'b0, 0, 2 * Setup + Pulse + 1 + Gap + 2);
    chk("abort_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("abort_ready_low", {31'd0, ready}, 32'd0);
    push_init();
    rst_n = 1'b1;
    measure_low(n);
    chk("reinit_drained", exp_q.size(), 0);
    send(8'h02, 1'b1, 0, 0);

    repeat (20) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
